// File: rtl/fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// fb_write_arbiter
//
// Write-side controller for port A of the 256x240x6-bit NES frame buffer BRAM,
// running entirely in the NES clock domain. Three requesters share the single
// write port:
//   * PPU pixels    - detected from changes of cycle/scanline, never stalled,
//                     so they always win arbitration.
//   * clear engine  - walks addresses 0..61439 writing a latched fill colour.
//   * OSD writer    - external req/ack requester.
// Clear and OSD share the cycles left over by the PPU round-robin.
//
// Pipeline: requests are arbitrated combinationally and the winning write is
// captured in a grant stage (r_g_*) at edge N; the output registers drive the
// BRAM port after edge N+1. Every output is a flop.
//
// OSD handshake: the requester raises osd_req with osd_addr/osd_data and holds
// all three stable until it samples osd_ack=1 (a one-cycle pulse). It may
// present the next request on the cycle after the ack. Because the ack emerges
// two edges after the grant, osd_req is ignored while a grant is in flight
// (r_g_osd) and while osd_ack is high, so a held request is never taken twice.
// Targets with y >= 240 are acknowledged without writing.
//
// Configuration macro: FB_OVERSCAN_MASK_EN
//   defined   - PPU pixels on the top/bottom MASK_LINES lines are written with
//               MASK_COLOR instead of color. Clear and OSD data are untouched.
//   undefined - color is always written; MASK_LINES/MASK_COLOR are unused.
//
// Ports:
//   clk          in   NES clock
//   reset        in   asynchronous active-high reset
//   color        in   [5:0]  PPU palette index
//   cycle        in   [8:0]  PPU dot
//   scanline     in   [8:0]  PPU line
//   clear_start  in   pulse, starts a frame clear (ignored while clearing)
//   clear_color  in   [5:0]  fill value, sampled with an accepted clear_start
//   clear_busy   out  clear in progress
//   osd_req      in   OSD write request, held until osd_ack
//   osd_addr     in   [15:0] OSD target {y[7:0], x[7:0]}
//   osd_data     in   [5:0]  OSD palette index
//   osd_ack      out  one-cycle pulse, OSD request consumed
//   fb_we        out  BRAM port A write enable
//   fb_addr      out  [15:0] BRAM port A address
//   fb_wdata     out  [5:0]  BRAM port A write data
//   frame_done   out  one-cycle pulse at the end of the visible frame
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fb_write_arbiter #(
  parameter int         MASK_LINES = 8,
  parameter logic [5:0] MASK_COLOR = 6'h0F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  color,
  input  logic [8:0]  cycle,
  input  logic [8:0]  scanline,
  input  logic        clear_start,
  input  logic [5:0]  clear_color,
  output logic        clear_busy,
  input  logic        osd_req,
  input  logic [15:0] osd_addr,
  input  logic [5:0]  osd_data,
  output logic        osd_ack,
  output logic        fb_we,
  output logic [15:0] fb_addr,
  output logic [5:0]  fb_wdata,
  output logic        frame_done
);

  localparam logic [15:0] LAST_ADDR  = 16'd61439;  // 256*240 - 1
  localparam logic [15:0] OSD_LIMIT  = 16'd61440;  // first address with y = 240
  localparam logic [8:0]  VIS_LINES  = 9'd240;
  localparam logic [8:0]  LAST_LINE  = 9'd239;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [8:0]  r_cycle;
  logic [8:0]  r_scanline;
  state_t      r_state;
  logic [15:0] r_caddr;
  logic [5:0]  r_clr_color;
  logic        r_last_clr;    // 1: clear was granted last, 0: OSD was

  // Grant stage: the write chosen at edge N, driven to the port at edge N+1.
  logic        r_g_we;
  logic        r_g_osd;
  logic [15:0] r_g_addr;
  logic [5:0]  r_g_data;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic        w_pix_new;
  logic [5:0]  w_pix_data;
  logic        w_clr_pend;
  logic        w_osd_pend;
  logic        w_gnt_pix;
  logic        w_gnt_clr;
  logic        w_gnt_osd;
  logic        w_osd_in_range;

  state_t      w_state_nx;
  logic [15:0] w_caddr_nx;
  logic [5:0]  w_clr_color_nx;
  logic        w_last_clr_nx;

  logic        w_g_we_nx;
  logic [15:0] w_g_addr_nx;
  logic [5:0]  w_g_data_nx;

  // ---------------------------------------------------------------------------
  // Pixel detection
  // ---------------------------------------------------------------------------
  // A new dot is any change of position landing on a visible line and in the
  // first 256 dots. The address ignores bit 8 of both coordinates because they
  // are zero whenever this fires.
  assign w_pix_new = ((r_cycle != cycle) || (r_scanline != scanline)) &&
                     (scanline < VIS_LINES) && !cycle[8];

`ifdef FB_OVERSCAN_MASK_EN
  localparam logic [8:0] MASK_TOP = 9'(MASK_LINES);
  localparam logic [8:0] MASK_BOT = 9'(240 - MASK_LINES);

  assign w_pix_data = ((scanline < MASK_TOP) || (scanline >= MASK_BOT)) ?
                      MASK_COLOR : color;
`else
  assign w_pix_data = color;

  logic w_unused_cfg;
  assign w_unused_cfg = (^MASK_COLOR) ^ (MASK_LINES != 0);
`endif

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign w_clr_pend     = (r_state == ST_CLEAR);
  // A held request is blind while its grant is in flight or being acked.
  assign w_osd_pend     = osd_req && !r_g_osd && !osd_ack;
  assign w_osd_in_range = (osd_addr < OSD_LIMIT);

  always_comb begin
    w_gnt_pix = 1'b0;
    w_gnt_clr = 1'b0;
    w_gnt_osd = 1'b0;
    if (w_pix_new) begin
      w_gnt_pix = 1'b1;
    end else if (w_clr_pend && w_osd_pend) begin
      // Both waiting: serve whichever was not served last.
      if (r_last_clr) begin
        w_gnt_osd = 1'b1;
      end else begin
        w_gnt_clr = 1'b1;
      end
    end else if (w_clr_pend) begin
      w_gnt_clr = 1'b1;
    end else if (w_osd_pend) begin
      w_gnt_osd = 1'b1;
    end
  end

  always_comb begin
    w_last_clr_nx = r_last_clr;
    if (w_gnt_clr) begin
      w_last_clr_nx = 1'b1;
    end else if (w_gnt_osd) begin
      w_last_clr_nx = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Clear FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nx     = r_state;
    w_caddr_nx     = r_caddr;
    w_clr_color_nx = r_clr_color;
    case (r_state)
      ST_IDLE: begin
        if (clear_start) begin
          w_state_nx     = ST_CLEAR;
          w_caddr_nx     = 16'd0;
          w_clr_color_nx = clear_color;
        end
      end
      ST_CLEAR: begin
        // clear_start is deliberately not looked at here: no restart.
        if (w_gnt_clr) begin
          if (r_caddr == LAST_ADDR) begin
            w_state_nx = ST_IDLE;
          end else begin
            w_caddr_nx = r_caddr + 16'd1;
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write mux into the grant stage
  // ---------------------------------------------------------------------------
  always_comb begin
    w_g_we_nx   = 1'b0;
    w_g_addr_nx = r_g_addr;
    w_g_data_nx = r_g_data;
    if (w_gnt_pix) begin
      w_g_we_nx   = 1'b1;
      w_g_addr_nx = {scanline[7:0], cycle[7:0]};
      w_g_data_nx = w_pix_data;
    end else if (w_gnt_clr) begin
      w_g_we_nx   = 1'b1;
      w_g_addr_nx = r_caddr;
      w_g_data_nx = r_clr_color;
    end else if (w_gnt_osd && w_osd_in_range) begin
      w_g_we_nx   = 1'b1;
      w_g_addr_nx = osd_addr;
      w_g_data_nx = osd_data;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle     <= 9'd0;
      r_scanline  <= 9'd0;
      r_state     <= ST_IDLE;
      r_caddr     <= 16'd0;
      r_clr_color <= 6'd0;
      r_last_clr  <= 1'b0;
      r_g_we      <= 1'b0;
      r_g_osd     <= 1'b0;
      r_g_addr    <= 16'd0;
      r_g_data    <= 6'd0;
    end else begin
      r_cycle     <= cycle;
      r_scanline  <= scanline;
      r_state     <= w_state_nx;
      r_caddr     <= w_caddr_nx;
      r_clr_color <= w_clr_color_nx;
      r_last_clr  <= w_last_clr_nx;
      r_g_we      <= w_g_we_nx;
      r_g_osd     <= w_gnt_osd;
      r_g_addr    <= w_g_addr_nx;
      r_g_data    <= w_g_data_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb_we      <= 1'b0;
      fb_addr    <= 16'd0;
      fb_wdata   <= 6'd0;
      osd_ack    <= 1'b0;
      clear_busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      fb_we      <= r_g_we;
      fb_addr    <= r_g_addr;
      fb_wdata   <= r_g_data;
      osd_ack    <= r_g_osd;
      clear_busy <= (r_state == ST_CLEAR);
      frame_done <= (r_scanline == LAST_LINE) && (scanline == VIS_LINES);
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
`timescale 1ns/1ps

module tb_fb_write_arbiter;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  color;
  logic [8:0]  cycle;
  logic [8:0]  scanline;
  logic        clear_start;
  logic [5:0]  clear_color;
  logic        clear_busy;
  logic        osd_req;
  logic [15:0] osd_addr;
  logic [5:0]  osd_data;
  logic        osd_ack;
  logic        fb_we;
  logic [15:0] fb_addr;
  logic [5:0]  fb_wdata;
  logic        frame_done;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fb_write_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .color       (color),
    .cycle       (cycle),
    .scanline    (scanline),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .osd_req     (osd_req),
    .osd_addr    (osd_addr),
    .osd_data    (osd_data),
    .osd_ack     (osd_ack),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_wdata    (fb_wdata),
    .frame_done  (frame_done)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  logic [21:0] pix_q[$];     // {addr, data} of expected pixel writes
  int          pix_t_q[$];   // cycle at which each pixel write must appear
  logic [21:0] osd_q[$];     // {addr, data} of issued OSD requests
  int          osd_t_q[$];   // cycle each request was presented
  int          fd_q[$];      // cycle at which each frame_done must appear

  bit          clr_on     = 1'b0;  // a clear is expected to be writing
  int          exp_caddr  = 0;
  logic [5:0]  exp_ccolor = 6'h00;
  int          clr_writes = 0;
  int          clr_first_t = 0;
  int          clr_last_t  = 0;
  int          osd_lat_max = 2;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Colour the frame buffer should receive for a PPU dot on line sl.
  function automatic logic [5:0] pix_color(input logic [8:0] sl, input logic [5:0] col);
`ifdef FB_OVERSCAN_MASK_EN
    if (sl < 9'd8 || sl >= 9'd232) return 6'h0F;
`endif
    return col;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: pops the expected queues whenever the DUT presents an output
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : monitor
    logic [21:0] e;
    int          t;
    int          lat;
    if (reset !== 1'b1) begin
      if (osd_ack) begin
        if (osd_q.size() == 0) begin
          check("osd_ack_without_request", 32'(osd_ack), 32'd0);
        end else begin
          e   = osd_q.pop_front();
          t   = osd_t_q.pop_front();
          lat = cyc - t;
          if (e[21:6] < 16'd61440) begin
            check("osd_we", 32'(fb_we), 32'd1);
            check("osd_addr", 32'(fb_addr), 32'(e[21:6]));
            check("osd_data", 32'(fb_wdata), 32'(e[5:0]));
          end else begin
            check("osd_out_of_range_we", 32'(fb_we), 32'd0);
          end
          check("osd_ack_latency_in_bound", 32'(lat >= 2 && lat <= osd_lat_max), 32'd1);
        end
      end else if (fb_we) begin
        if (pix_q.size() > 0 && {fb_addr, fb_wdata} == pix_q[0]) begin
          e = pix_q.pop_front();
          t = pix_t_q.pop_front();
          check("pix_write_cycle", 32'(cyc), 32'(t));
        end else if (clr_on) begin
          if (clr_writes == 0) begin
            clr_first_t = cyc;
            check("clear_busy_at_first_write", 32'(clear_busy), 32'd1);
          end
          if (clr_writes == 61438) begin
            check("clear_busy_before_last_write", 32'(clear_busy), 32'd1);
          end
          check("clr_addr", 32'(fb_addr), 32'(exp_caddr));
          check("clr_data", 32'(fb_wdata), 32'(exp_ccolor));
          clr_last_t = cyc;
          clr_writes++;
          exp_caddr++;
          if (exp_caddr == 61440) clr_on = 1'b0;
        end else begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h, required no write (cycle %0d)",
                   fb_addr, fb_wdata, cyc);
        end
      end
      if (frame_done) begin
        if (fd_q.size() == 0) begin
          check("frame_done_unexpected", 32'(frame_done), 32'd0);
        end else begin
          t = fd_q.pop_front();
          check("frame_done_cycle", 32'(cyc), 32'(t));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all called just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix_step(input logic [8:0] sl, input logic [8:0] cy,
                          input logic [5:0] col, input int hold);
    logic [8:0] old_sl;
    logic [8:0] old_cy;
    old_sl   = scanline;
    old_cy   = cycle;
    scanline = sl;
    cycle    = cy;
    color    = col;
    if ((sl != old_sl || cy != old_cy) && sl < 9'd240 && cy < 9'd256) begin
      pix_q.push_back({sl[7:0], cy[7:0], pix_color(sl, col)});
      pix_t_q.push_back(cyc + 2);
    end
    if (old_sl == 9'd239 && sl == 9'd240) fd_q.push_back(cyc + 1);
    repeat (hold) tick();
  endtask

  task automatic osd_write(input logic [15:0] addr, input logic [5:0] data);
    bit got;
    osd_req  = 1'b1;
    osd_addr = addr;
    osd_data = data;
    osd_q.push_back({addr, data});
    osd_t_q.push_back(cyc);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (osd_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("osd_ack_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic start_clear(input logic [5:0] col);
    clr_on      = 1'b1;
    exp_caddr   = 0;
    exp_ccolor  = col;
    clr_writes  = 0;
    clear_start = 1'b1;
    clear_color = col;
    tick();
    clear_start = 1'b0;
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    summary();
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit did_restart;
    reset       = 1'b1;
    color       = 6'h00;
    cycle       = 9'd0;
    scanline    = 9'd0;
    clear_start = 1'b0;
    clear_color = 6'h00;
    osd_req     = 1'b0;
    osd_addr    = 16'h0000;
    osd_data    = 6'h00;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset_fb_we", 32'(fb_we), 32'd0);
    check("reset_fb_addr", 32'(fb_addr), 32'd0);
    check("reset_fb_wdata", 32'(fb_wdata), 32'd0);
    check("reset_osd_ack", 32'(osd_ack), 32'd0);
    check("reset_clear_busy", 32'(clear_busy), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    #2 reset = 1'b0;
    repeat (3) tick();

    // PPU pixels: directed step, invalid positions, frame end, then random
    pix_step(9'd5, 9'd10, 6'h21, 4);
    pix_step(9'd5, 9'd11, 6'h21, 4);
    pix_step(9'd240, 9'd11, 6'h22, 4);
    pix_step(9'd5, 9'd256, 6'h23, 4);
    pix_step(9'd239, 9'd100, 6'h24, 4);
    pix_step(9'd240, 9'd100, 6'h25, 4);
    pix_step(9'd241, 9'd100, 6'h26, 4);
    pix_step(9'd2, 9'd3, 6'h27, 4);
    for (int i = 0; i < 120; i++) begin
      pix_step(9'($urandom_range(0, 261)), 9'($urandom_range(0, 340)),
               6'($urandom_range(0, 63)), $urandom_range(4, 6));
    end
    repeat (6) tick();

    // OSD alone: directed in-range and out-of-range, then random
    osd_lat_max = 2;
    osd_write(16'hF000, 6'h31);
    osd_write(16'h1020, 6'h32);
    for (int i = 0; i < 30; i++) begin
      osd_write(16'($urandom_range(0, 65535)), 6'($urandom_range(0, 63)));
    end
    osd_req = 1'b0;
    repeat (5) tick();

    // Full clear with no other traffic; a second clear_start mid-way is ignored
    start_clear(6'h0F);
    did_restart = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      if (clr_writes >= 30000 && !did_restart) begin
        did_restart = 1'b1;
        clear_start = 1'b1;
        clear_color = 6'h2A;
        tick();
        clear_start = 1'b0;
      end else begin
        tick();
      end
      if (clr_writes >= 61440) break;
    end
    check("clear_write_count", 32'(clr_writes), 32'd61440);
    check("clear_writes_consecutive", 32'(clr_last_t - clr_first_t), 32'd61439);
    @(negedge clk);
    check("clear_busy_after_last_write", 32'(clear_busy), 32'd0);
    check("no_write_after_clear", 32'(fb_we), 32'd0);
    tick();
    repeat (5) tick();

    // Contention: clear running with OSD held at one address, then with pixels
    start_clear(6'h0F);
    repeat (3) tick();
    osd_lat_max = 3;
    for (int i = 0; i < 40; i++) begin
      osd_write(16'h1020, 6'($urandom_range(0, 63)));
    end
    osd_lat_max = 12;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          pix_step(9'($urandom_range(100, 139)), 9'($urandom_range(0, 255)),
                   6'($urandom_range(0, 63)), $urandom_range(4, 7));
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          osd_write((i % 8 == 7) ? 16'hF000 : 16'($urandom_range(0, 61439)),
                    6'($urandom_range(0, 63)));
        end
        osd_req = 1'b0;
      end
    join
    osd_req = 1'b0;
    pix_step(9'd0, 9'd0, 6'h05, 8);

    // Reset in the middle of the clear, near caddr = 1000
    for (int i = 0; i < 3000; i++) begin
      if (clr_writes >= 1000) break;
      tick();
    end
    check("clear_reached_1000_before_reset", 32'(clr_writes >= 1000), 32'd1);
    @(negedge clk);
    #2;
    reset  = 1'b1;
    clr_on = 1'b0;
    #1;
    check("async_reset_fb_we", 32'(fb_we), 32'd0);
    check("async_reset_fb_addr", 32'(fb_addr), 32'd0);
    check("async_reset_fb_wdata", 32'(fb_wdata), 32'd0);
    check("async_reset_osd_ack", 32'(osd_ack), 32'd0);
    check("async_reset_clear_busy", 32'(clear_busy), 32'd0);
    check("async_reset_frame_done", 32'(frame_done), 32'd0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    repeat (40) tick();
    check("idle_after_reset_busy", 32'(clear_busy), 32'd0);
    check("idle_after_reset_we", 32'(fb_we), 32'd0);

    // A fresh pixel is written normally after the reset
    pix_step(9'd7, 9'd7, 6'h15, 6);
    repeat (4) tick();

    check("pixel_queue_drained", 32'(pix_q.size()), 32'd0);
    check("osd_queue_drained", 32'(osd_q.size()), 32'd0);
    check("frame_done_queue_drained", 32'(fd_q.size()), 32'd0);

    summary();
    $finish;
  end

endmodule
